// File: rtl/gcd_proc_pkg.sv
// Shared constants for the number-theory datapath (GCD and LCM processors).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gcd_proc_pkg;

  // Default operand/result width, shared with the LCM processor.
  localparam int GCD_W_DEF = 4;

  // FSM state encodings. The two spare codes are treated as IDLE recovery.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;

endpackage

// File: rtl/gcd_step.sv
// Combinational compare/subtract step for the subtractive GCD loop.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow a/b directly.
//
// Ports:
//   a, b  : W-bit unsigned operands
//   eq    : a == b
//   gt    : a > b
//   az    : a == 0
//   bz    : b == 0
//   diff  : larger minus smaller (never underflows)
module gcd_step
  import gcd_proc_pkg::*;
#(
  parameter int W = GCD_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         az,
  output logic         bz,
  output logic [W-1:0] diff
);

  assign eq   = (a == b);
  assign gt   = (a > b);
  assign az   = (a == '0);
  assign bz   = (b == '0);
  // Ordering the operands first means the result always fits in W bits.
  assign diff = gt ? (a - b) : (b - a);

endmodule

// File: rtl/gcd_proc.sv
// Iterative subtractive GCD engine: one subtraction per clock until convergence.
// Latency: done_o rises S+2 cycles after the accepting go edge (counting that edge), S = subtraction steps.
// Backpressure: go_i is honoured only in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clk    : system clock, all state changes on posedge
//   rst    : synchronous active-high reset, overrides everything
//   go_i   : start request, sampled only in IDLE
//   x_i    : operand X, captured on an accepted go_i
//   y_i    : operand Y, captured on an accepted go_i
//   busy_o : high while the engine is iterating
//   done_o : one-cycle pulse, d_o/err_o updated on this cycle
//   d_o    : GCD result, held until the next done_o
//   err_o  : set when both operands were zero, held with d_o
module gcd_proc
  import gcd_proc_pkg::*;
#(
  parameter int W = GCD_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] d_o,
  output logic         err_o
);

  logic [1:0]   state;
  logic [W-1:0] xr;
  logic [W-1:0] yr;

  logic         s_eq;
  logic         s_gt;
  logic         s_az;
  logic         s_bz;
  logic [W-1:0] s_diff;

  gcd_step #(.W(W)) u_step (
    .a    (xr),
    .b    (yr),
    .eq   (s_eq),
    .gt   (s_gt),
    .az   (s_az),
    .bz   (s_bz),
    .diff (s_diff)
  );

  assign busy_o = (state == ST_CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      // Any in-flight operation is abandoned without a done pulse.
      state  <= ST_IDLE;
      xr     <= '0;
      yr     <= '0;
      d_o    <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      // done_o is a single-cycle pulse unless a terminal case re-asserts it.
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Also reached in the done_o cycle, so back-to-back starts need no bubble.
          if (go_i) begin
            xr    <= x_i;
            yr    <= y_i;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (s_az && s_bz) begin
            d_o    <= '0;
            err_o  <= 1'b1;
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end else if (s_az) begin
            d_o    <= yr;
            err_o  <= 1'b0;
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end else if (s_bz) begin
            d_o    <= xr;
            err_o  <= 1'b0;
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end else if (s_eq) begin
            d_o    <= xr;
            err_o  <= 1'b0;
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end else if (s_gt) begin
            xr <= s_diff;
          end else begin
            yr <= s_diff;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_proc.sv
// Directed bench for gcd_proc: fixed vectors, back-to-back, ignored go, mid-run reset, full W=4 sweep.
// Latency: measured in posedges from the accepting go edge (counted as 1) to the done edge.
// Backpressure: go_i is only driven while the DUT should be idle, except the deliberate ignored-go case.
module tb_gcd_proc;

  logic       clk;
  logic       rst;
  logic       go_i;
  logic [3:0] x_i;
  logic [3:0] y_i;
  logic       busy_o;
  logic       done_o;
  logic [3:0] d_o;
  logic       err_o;

  int checks;
  int failures;

  gcd_proc #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .go_i   (go_i),
    .x_i    (x_i),
    .y_i    (y_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .d_o    (d_o),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Euclid-by-division reference. Subtractive steps per division stage equal the
  // quotient, except the final exact stage stops one short (operands become equal).
  function automatic void gcd_ref(input int x, input int y,
                                  output int d, output int e, output int lat);
    int a, b, q, r, s;
    s = 0;
    e = 0;
    if (x == 0 && y == 0) begin
      d = 0;
      e = 1;
    end else if (x == 0) begin
      d = y;
    end else if (y == 0) begin
      d = x;
    end else begin
      a = (x > y) ? x : y;
      b = (x > y) ? y : x;
      d = 0;
      while (1) begin
        q = a / b;
        r = a % b;
        if (r == 0) begin
          s += q - 1;
          d = b;
          break;
        end
        s += q;
        a = b;
        b = r;
      end
    end
    lat = s + 2;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a posedge. Returns #1 after the done edge.
  // inj > 0 pulses go_i with (3,3) during that busy cycle to check it is ignored.
  task automatic run_op(input int x, input int y, input int inj);
    int    ed, ee, el, cnt;
    string tg;
    gcd_ref(x, y, ed, ee, el);
    tg = $sformatf("(%0d,%0d)", x, y);
    go_i = 1'b1;
    x_i  = 4'(x);
    y_i  = 4'(y);
    @(posedge clk);
    #1;
    go_i = 1'b0;
    cnt  = 1;
    chk({tg, " busy_after_go"}, 32'(busy_o), 32'd1);
    chk({tg, " done_low_after_go"}, 32'(done_o), 32'd0);
    while (!done_o && cnt < 40) begin
      if (cnt == inj) begin
        go_i = 1'b1;
        x_i  = 4'd3;
        y_i  = 4'd3;
      end
      @(posedge clk);
      #1;
      go_i = 1'b0;
      cnt++;
    end
    chk({tg, " done_seen"}, 32'(done_o), 32'd1);
    chk({tg, " latency"}, 32'(cnt), 32'(el));
    chk({tg, " d"}, 32'(d_o), 32'(ed));
    chk({tg, " err"}, 32'(err_o), 32'(ee));
    chk({tg, " busy_at_done"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    go_i = 1'b0;
    x_i  = 4'd0;
    y_i  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset d", 32'(d_o), 32'd0);
    chk("reset err", 32'(err_o), 32'd0);
    rst = 1'b0;
    idle(1);

    // Basic operation; result and done pulse width checked afterwards.
    run_op(12, 8, 0);
    idle(1);
    chk("pulse one cycle", 32'(done_o), 32'd0);
    idle(2);
    chk("d hold 12,8", 32'(d_o), 32'd4);

    // Worst case, then a zero-bubble start in its done cycle.
    run_op(15, 1, 0);
    run_op(9, 6, 0);
    idle(1);

    run_op(7, 7, 0);
    idle(1);
    run_op(0, 9, 0);
    idle(1);
    run_op(0, 0, 0);
    idle(3);
    chk("err hold", 32'(err_o), 32'd1);
    run_op(5, 0, 0);
    idle(1);

    // go_i on the second busy cycle must not disturb the running operation.
    run_op(14, 4, 2);
    idle(1);
    chk("ignored go not started", 32'(busy_o), 32'd0);

    // Reset on the 5th busy cycle of a long operation.
    go_i = 1'b1;
    x_i  = 4'd15;
    y_i  = 4'd1;
    @(posedge clk);
    #1;
    go_i = 1'b0;
    idle(4);
    chk("busy before rst", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst mid busy", 32'(busy_o), 32'd0);
    chk("rst mid done", 32'(done_o), 32'd0);
    chk("rst mid d", 32'(d_o), 32'd0);
    chk("rst mid err", 32'(err_o), 32'd0);
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) seen = 1;
    end
    chk("no done after rst", 32'(seen), 32'd0);

    // Exhaustive sweep of all operand pairs.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        idle(1);
        run_op(x, y, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
